// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
//
// Shared definitions for the period meter and its input synchronizer.
//
// Contents:
//   DEF_WIDTH        default width of the period / high-time counters
//   DEF_SYNC_STAGES  default depth of the input synchronizer
//   DEF_MAX_COUNT    default count without a rising edge before "stuck"
//   meas_state_e     measurement state machine encoding (IDLE, MEAS)
// -----------------------------------------------------------------------------
package period_meter_pkg;

    localparam int unsigned DEF_WIDTH       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam logic [31:0] DEF_MAX_COUNT   = 32'hFFFF_FFFF;

    // IDLE: waiting for the first rising edge that arms a measurement.
    // MEAS: counting between rising edges.
    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } meas_state_e;

endpackage : period_meter_pkg

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//
// Brings a possibly asynchronous level into the clk domain and flags its
// rising edges. Shared by any block that samples an external input.
//
// Parameters:
//   STAGES   number of synchronizer flops (2 or more for metastability
//            settling; fewer is not a supported configuration)
//
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset, clears every flop to 0
//   async_i  external level, may be asynchronous to clk
//   lvl_o    synchronized level (last synchronizer stage)
//   rise_o   one-cycle pulse on a 0->1 transition of lvl_o
//
// An edge sampled on async_i at clk edge N shows up as rise_o during the
// cycle after edge N+STAGES-1, so a block registering rise_o acts on it at
// edge N+STAGES.
// -----------------------------------------------------------------------------
module sync_edge
    import period_meter_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              lvl_dly_q;

    // New samples enter at bit 0 and shift toward the MSB, which is the
    // settled level handed to the rest of the design.
    assign sync_d = {sync_q[STAGES-2:0], async_i};

    // Synchronizer chain plus one extra flop holding the previous settled
    // level, used only for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_dly_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~lvl_dly_q;

endmodule : sync_edge

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures a square wave in system-clock cycles: the distance between the
// last two rising edges (period) and how many of those cycles the input was
// high (high_time). Fed by a divide-by-k clock divider it reports period=k
// and high_time=k>>1.
//
// Parameters:
//   WIDTH        width of the counters and of period / high_time
//   SYNC_STAGES  synchronizer depth for sig_in (2 or more)
//   MAX_COUNT    cycles without a rising edge before stuck is raised;
//                must fit in WIDTH bits
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   en         measurement enable, synchronous to clk
//   sig_in     signal under measurement, may be asynchronous to clk
//   period     clk cycles between the last two rising edges of sig_in
//   high_time  clk cycles sig_in was high within that period
//   valid      one-cycle pulse when period / high_time update
//   stuck      sticky flag: no rising edge for MAX_COUNT cycles
// -----------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(DEF_MAX_COUNT)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             stuck
);

    logic lvl;
    logic rise;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (sig_in),
        .lvl_o   (lvl),
        .rise_o  (rise)
    );

    meas_state_e      state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] hcnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_q;
    logic             valid_q;
    logic             stuck_q;

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] hcnt_d;
    logic             at_limit;

    // Running counts for a cycle with no rising edge. The counters never
    // wrap because the MAX_COUNT check stops counting first.
    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        hcnt_d = hcnt_q + WIDTH'(lvl);
    end

    assign at_limit = (cnt_q == MAX_COUNT);

    // Measurement state machine. The rising-edge cycle itself is counted as
    // the first cycle of the new period and, being high, as its first high
    // cycle; hence both counters restart at 1 rather than 0. A rise in the
    // same cycle that the limit is reached still counts as a measurement.
    // Dropping en abandons the current measurement but keeps the last
    // reported result on period / high_time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= MEAS;
                        cnt_q   <= WIDTH'(1);
                        hcnt_q  <= WIDTH'(1);
                        stuck_q <= 1'b0;
                    end else begin
                        cnt_q  <= '0;
                        hcnt_q <= '0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        valid_q  <= 1'b1;
                        cnt_q    <= WIDTH'(1);
                        hcnt_q   <= WIDTH'(1);
                    end else if (at_limit) begin
                        state_q <= IDLE;
                        stuck_q <= 1'b1;
                        cnt_q   <= '0;
                        hcnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_d;
                        hcnt_q <= hcnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    hcnt_q  <= '0;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;

endmodule : period_meter

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Two meters share clk, rstn and en: dutA with the default MAX_COUNT for
// divider measurements, reset and enable sequences; dutB with MAX_COUNT=64
// for the stuck and limit-edge cases.
// -----------------------------------------------------------------------------
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 3;   // sig_in edge to counted rise: SYNC_STAGES+1

    typedef struct {
        int          stamp;
        logic [W-1:0] per;
        logic [W-1:0] hi;
    } event_t;

    typedef struct {
        int k;
        int hi;
        int periods;
        int expPer;
        int expHi;
    } vec_t;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic         en   = 1'b0;
    logic         sigA = 1'b0;
    logic         sigB = 1'b0;
    logic [W-1:0] periodA, highA, periodB, highB;
    logic         validA, stuckA, validB, stuckB;

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;

    event_t gotA[$], expA[$], gotB[$], expB[$];
    int     lastRiseA = -1, lastRiseB = -1;
    int     pendPerA, pendHiA, pendPerB, pendHiB;

    logic lastValidA = 1'b0, lastValidB = 1'b0, lastStuckA = 1'b0, lastStuckB = 1'b0;
    int   b2bA = 0, b2bB = 0, stuckRiseA = 0, stuckRiseB = 0, stuckClearCycB = -1;

    period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dutA (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .sig_in    (sigA),
        .period    (periodA),
        .high_time (highA),
        .valid     (validA),
        .stuck     (stuckA)
    );

    period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .MAX_COUNT   (32'd64)
    ) dutB (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .sig_in    (sigB),
        .period    (periodB),
        .high_time (highB),
        .valid     (validB),
        .stuck     (stuckB)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse and watch the one-cycle / stuck properties.
    always @(negedge clk) begin
        if (validA) gotA.push_back('{cyc, periodA, highA});
        if (validB) gotB.push_back('{cyc, periodB, highB});
        if (validA && lastValidA) b2bA++;
        if (validB && lastValidB) b2bB++;
        if (stuckA && !lastStuckA) stuckRiseA++;
        if (stuckB && !lastStuckB) stuckRiseB++;
        if (!stuckB && lastStuckB) stuckClearCycB = cyc;
        lastValidA = validA;
        lastValidB = validB;
        lastStuckA = stuckA;
        lastStuckB = stuckB;
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic resetModel(input int which);
        if (which == 0) begin
            lastRiseA = -1;
            gotA.delete();
            expA.delete();
        end else begin
            lastRiseB = -1;
            gotB.delete();
            expB.delete();
        end
    endtask

    // A rising edge driven now completes the previous period (if armed);
    // its result is due LAT cycles later.
    task automatic noteRise(input int which, input int expPer, input int expHi);
        if (which == 0) begin
            if (lastRiseA >= 0) expA.push_back('{cyc + LAT, W'(pendPerA), W'(pendHiA)});
            lastRiseA = cyc;
            pendPerA  = expPer;
            pendHiA   = expHi;
        end else begin
            if (lastRiseB >= 0) expB.push_back('{cyc + LAT, W'(pendPerB), W'(pendHiB)});
            lastRiseB = cyc;
            pendPerB  = expPer;
            pendHiB   = expHi;
        end
    endtask

    task automatic setSig(input int which, input logic v);
        if (which == 0) sigA = v;
        else            sigB = v;
    endtask

    // One divider period: hi cycles high, k-hi cycles low. Called and
    // returns at 1 time unit after a rising clk edge.
    task automatic drivePeriod(input int which, input int k, input int hi,
                               input int expPer, input int expHi);
        noteRise(which, expPer, expHi);
        setSig(which, 1'b1);
        repeat (hi) @(posedge clk);
        #1;
        setSig(which, 1'b0);
        repeat (k - hi) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int p = 0; p < v.periods; p++)
            drivePeriod(0, v.k, v.hi, v.expPer, v.expHi);
    endtask

    task automatic checkEvents(input int which, input string tag);
        event_t g[$];
        event_t e[$];
        if (which == 0) begin
            g = gotA;
            e = expA;
        end else begin
            g = gotB;
            e = expB;
        end
        checkOutput({tag, " count"}, W'(g.size()), W'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < g.size()) begin
                checkOutput($sformatf("%s[%0d] cycle", tag, i), W'(g[i].stamp), W'(e[i].stamp));
                checkOutput($sformatf("%s[%0d] period", tag, i), g[i].per, e[i].per);
                checkOutput($sformatf("%s[%0d] high", tag, i), g[i].hi, e[i].hi);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int stampAt;
        int c0;
        int ce;
        int m1;
        int expStamp;
        int validDuringEn;

        vecs[0] = '{100, 50, 4, 100, 50};
        vecs[1] = '{5,   2,  6, 5,   2};
        vecs[2] = '{2,   1,  8, 2,   1};
        vecs[3] = '{8,   4,  4, 8,   4};
        vecs[4] = '{3,   1,  4, 3,   1};
        vecs[5] = '{7,   3,  3, 7,   3};

        // ---------------- reset state ----------------
        en = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset A period", periodA, 0);
        checkOutput("reset A high", highA, 0);
        checkOutput("reset A valid", W'(validA), 0);
        checkOutput("reset A stuck", W'(stuckA), 0);
        checkOutput("reset B period", periodB, 0);
        checkOutput("reset B high", highB, 0);
        checkOutput("reset B valid", W'(validB), 0);
        checkOutput("reset B stuck", W'(stuckB), 0);
        #2 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- divider table on dutA ----------------
        $display("[TB] divider table");
        resetModel(0);
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        drivePeriod(0, 8, 4, 8, 4);   // closing edge for the last table period
        repeat (6) @(posedge clk);
        #1;
        checkEvents(0, "table");
        checkOutput("table A stuck rises", W'(stuckRiseA), 0);

        // ---------------- stuck detection on dutB ----------------
        $display("[TB] stuck detection");
        resetModel(1);
        for (int p = 0; p < 4; p++) drivePeriod(1, 20, 10, 20, 10);
        stampAt = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stuckB) begin
                stampAt = cyc;
                break;
            end
        end
        checkOutput("stuck assert cycle", W'(stampAt), W'(lastRiseB + LAT + 64));
        checkOutput("stuck period hold", periodB, 20);
        checkOutput("stuck high hold", highB, 10);
        checkEvents(1, "prestuck");

        // ---------------- resume, then pulses at exactly MAX_COUNT ----------------
        $display("[TB] resume and limit-edge pulses");
        @(posedge clk);
        #1;
        resetModel(1);
        stuckRiseB     = 0;
        stuckClearCycB = -1;
        c0 = cyc;
        for (int p = 0; p < 2; p++) drivePeriod(1, 20, 10, 20, 10);
        for (int p = 0; p < 4; p++) drivePeriod(1, 64, 32, 64, 32);
        drivePeriod(1, 8, 4, 8, 4);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("stuck clear cycle", W'(stuckClearCycB), W'(c0 + LAT));
        checkOutput("limit-edge stuck rises", W'(stuckRiseB), 0);
        checkEvents(1, "resume");

        // ---------------- async reset mid-period ----------------
        $display("[TB] async reset");
        repeat (80) @(posedge clk);
        #1;
        checkOutput("pre-reset B stuck", W'(stuckB), 1);
        for (int p = 0; p < 3; p++) drivePeriod(0, 8, 4, 8, 4);
        checkOutput("pre-reset A period", periodA, 8);
        sigA = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        sigA = 1'b0;
        #1;
        checkOutput("async reset A period", periodA, 0);
        checkOutput("async reset A high", highA, 0);
        checkOutput("async reset A valid", W'(validA), 0);
        checkOutput("async reset B stuck", W'(stuckB), 0);
        checkOutput("async reset B period", periodB, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetModel(0);
        for (int p = 0; p < 3; p++) drivePeriod(0, 8, 4, 8, 4);
        drivePeriod(0, 8, 4, 8, 4);
        repeat (6) @(posedge clk);
        #1;
        checkEvents(0, "postreset");

        // ---------------- en dropped during k=8 ----------------
        $display("[TB] enable drop");
        resetModel(0);
        c0 = cyc;
        validDuringEn = 0;
        ce = 0;
        stampAt = -1;
        fork
            begin
                for (int p = 0; p < 12; p++) drivePeriod(0, 8, 4, 8, 4);
            end
            begin
                repeat (21) @(posedge clk);
                #1;
                en = 1'b0;
                repeat (20) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (validA) validDuringEn++;
                end
                checkOutput("en-low valid count", W'(validDuringEn), 0);
                checkOutput("en-low period hold", periodA, 8);
                checkOutput("en-low high hold", highA, 4);
                checkOutput("en-low stuck", W'(stuckA), 0);
                @(posedge clk);
                #1;
                en = 1'b1;
                ce = cyc;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (validA) begin
                        stampAt = cyc;
                        break;
                    end
                end
                // first rise counted with en=1 only arms; the next one reports
                m1 = 0;
                while (c0 + 8 * m1 + LAT - 1 < ce) m1++;
                expStamp = c0 + 8 * (m1 + 1) + LAT;
                checkOutput("en-high first valid cycle", W'(stampAt), W'(expStamp));
                checkOutput("en-high period", periodA, 8);
                checkOutput("en-high high", highA, 4);
            end
        join

        checkOutput("A back-to-back valid", W'(b2bA), 0);
        checkOutput("B back-to-back valid", W'(b2bB), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_period_meter
